// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction image loader.
// State encodings, frame layout and a receive-state helper.
package inst_loader_pkg;

    localparam int LD_XLEN      = 32;
    localparam int LD_LEN_BYTES = 4;

    localparam logic [2:0] S_LEN   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    function automatic logic rx_state(input logic [2:0] s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/inst_loader_word_packer.sv
// Little-endian byte-to-word packer with a 2-bit byte counter.
// word_o is the word as it would be after shifting in byte_i.
module loader_word_packer
    import inst_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  byte_i,
    input  logic                        shift_i,
    output logic [8*LD_LEN_BYTES-1:0]   word_o,
    output logic                        word_valid_o
);

    logic [8*LD_LEN_BYTES-9:0] sreg;
    logic [1:0]                cnt;

    // Newest byte enters at the top so byte 0 ends up in bits 7:0.
    assign word_o       = {byte_i, sreg};
    assign word_valid_o = shift_i && (cnt == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (shift_i) begin
            sreg <= word_o[8*LD_LEN_BYTES-1:8];
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a length/payload/checksum byte stream into instruction memory
// and releases the core from reset once the image verifies.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int              XLEN        = LD_XLEN,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int              DEPTH_WORDS = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      byte_i,
    input  logic            byte_valid_i,
    output logic            byte_ready_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ready_i,
    output logic            core_rst_o,
    output logic            done_o,
    output logic            err_o
);

    localparam int          WCW       = $clog2(DEPTH_WORDS) + 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    logic [2:0]      state;
    logic [2:0]      state_next;
    logic [WCW-1:0]  n_words;
    logic [WCW-1:0]  w_cnt;
    logic [WCW-1:0]  w_inc;
    logic [7:0]      csum;
    logic [31:0]     word;
    logic            word_valid;
    logic            accept;
    logic            shift;
    logic [XLEN-1:0] addr_off;

    assign accept   = byte_valid_i && byte_ready_o;
    assign shift    = accept && ((state == S_LEN) || (state == S_DATA));
    assign w_inc    = w_cnt + WCW'(1);
    assign addr_off = XLEN'({w_cnt, 2'b00});

    loader_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_i       (byte_i),
        .shift_i      (shift),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_next = state;
        unique case (1'b1)
            (state == S_LEN): begin
                if (word_valid) begin
                    if (word > DEPTH_LIM)
                        state_next = S_ERR;
                    else if (word == '0)
                        state_next = S_CSUM;
                    else
                        state_next = S_DATA;
                end
            end
            (state == S_DATA): begin
                if (word_valid)
                    state_next = S_WRITE;
            end
            (state == S_WRITE): begin
                if (mem_ready_i)
                    state_next = (w_inc == n_words) ? S_CSUM : S_DATA;
            end
            (state == S_CSUM): begin
                if (accept)
                    state_next = (byte_i == csum) ? S_DONE : S_ERR;
            end
            (state == S_DONE): state_next = S_DONE;
            (state == S_ERR):  state_next = S_ERR;
            default:           state_next = S_ERR;
        endcase
    end

    // Outputs are registered from the next state so they track state entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_LEN;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= BASE_ADDR;
            mem_wdata_o  <= '0;
            core_rst_o   <= 1'b1;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            n_words      <= '0;
            w_cnt        <= '0;
            csum         <= '0;
        end else begin
            state        <= state_next;
            byte_ready_o <= rx_state(state_next);
            mem_we_o     <= (state_next == S_WRITE);
            core_rst_o   <= (state_next != S_DONE);
            done_o       <= (state_next == S_DONE);
            err_o        <= (state_next == S_ERR);
            if ((state == S_LEN) && word_valid)
                n_words <= word[WCW-1:0];
            if ((state == S_DATA) && accept)
                csum <= csum + byte_i;
            if ((state == S_DATA) && word_valid) begin
                mem_addr_o  <= BASE_ADDR + addr_off;
                mem_wdata_o <= XLEN'(word);
            end
            if ((state == S_WRITE) && mem_ready_i)
                w_cnt <= w_inc;
        end
    end

endmodule
